memory: RTL and testbench
=========================

# memory

Memory-access pipeline stage, directly upstream of `writeback`. It accepts one executed instruction at a time from execute, issues at most one data-bus transaction per load/store, and formats store data and byte strobes. It captures the raw 64-bit load word and presents a registered `memory_data_t` to writeback. Byte extraction and sign extension of load data are done in writeback, not here.

## Interface
Parameters:
- `AW`, 64: data-bus address width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `dataE`  in  `execute_data_t`  executed instruction: `instr` (with `ctl`), `aluout` (effective address / result), `srcb` (store data), `csr_ctl`.
- `in_valid`  in  1  `dataE` is valid this cycle.
- `stall_mem`  out  1  stage busy; upstream must hold `dataE` / `in_valid`.
- `flush`  in  1  kill the instruction currently held in this stage.
- `dataM`  out  `memory_data_t`  registered result to writeback.
- `out_valid`  out  1  `dataM` is valid this cycle.
- `dreq_valid`  out  1  data-bus request valid.
- `dreq_addr`  out  AW  request address, 8-byte aligned (`aluout & ~7`).
- `dreq_size`  out  3  log2 of access bytes (0..3).
- `dreq_strobe`  out  8  byte-write enables; all zero for loads.
- `dreq_data`  out  64  lane-shifted store data.
- `dresp_addr_ok`  in  1  request accepted.
- `dresp_data_ok`  in  1  transaction complete; `dresp_data` valid.
- `dresp_data`  in  64  raw 64-bit read word.

## Operation
- Instruction states: IDLE, REQ (`dreq_valid` high, waiting for `addr_ok`), WAIT (waiting for `data_ok`).
- Accept when `in_valid & state==IDLE`. The instruction is latched internally.
- Non-memory instruction, or instruction with `dataE.csr_ctl.is_except` set: no bus access. `dataM` is registered next cycle.
- A load or store is a mem op when `ctl.memr_en | ctl.memw_en`. For an aligned mem op with no exception, go to REQ.
- Misalignment: `aluout[2:0]` is not a multiple of the access size.
  - Misaligned store: no request. `dataM.csr_ctl` gets `is_except=1`, `except_name=E_ST_MISALIGN`.
  - Misaligned load: no request. `memr_data=0`. Writeback raises the load exception.
- Strobe: `((1<<(1<<msize))-1) << aluout[2:0]`, truncated to 8 bits.
- `dreq_data`: `srcb << (8*aluout[2:0])`.
- REQ: hold `dreq_valid` and all `dreq_*` stable until `dresp_addr_ok`.
  - `addr_ok` without `data_ok`: go to WAIT.
  - `addr_ok & data_ok` in the same cycle: complete immediately.
- WAIT: on `data_ok`, latch `dresp_data` into `dataM.memr_data` (loads only; stores write 0) and return to IDLE.
- `dataM.instr`, `aluout` and `csr_ctl` are copied from the latched instruction.
- Flush:
  - IDLE/completion: `out_valid` is forced to 0 for the killed instruction.
  - REQ/WAIT: set `killed`. The bus transaction still runs to `data_ok`, because a request cannot be withdrawn. On completion `out_valid=0`.
  - `flush` and accept in the same cycle: the new instruction is not killed.
- `stall_mem = (state != IDLE)`.

## Timing
- Reset values: state IDLE, `out_valid=0`, `dataM='0`, `dreq_valid=0`, `dreq_strobe=0`, `stall_mem=0`, `killed=0`.
- Reset mid-transaction abandons it; the bus is reset in the same cycle.
- Non-mem latency: accept at cycle N, `out_valid` at N+1 for one cycle.
- Mem-op latency:
  - Accept at N, `dreq_valid` from N+1.
  - `data_ok` at cycle M ≥ N+1 gives `out_valid` at M+1.
  - Minimum is 2 cycles, with `addr_ok & data_ok` at N+1.
- `stall_mem` is high from N+1 through M inclusive.
- The next instruction can be accepted at M+1.
- `out_valid` is a one-cycle pulse per instruction. Writeback never back-pressures.
- `dresp_data_ok` arriving in IDLE is ignored.

## Test plan
- ALU op, `aluout=0x1234`, `in_valid` at cycle 0:
  - `out_valid`=1 at cycle 1 with `aluout=0x1234`.
  - `dreq_valid` never asserted.
- `sw` at `aluout=0x1004`, `srcb=0xDEADBEEF`, `addr_ok` delayed 3 cycles:
  - `dreq_addr=0x1000`, `strobe=0xF0`, `dreq_data=0xDEADBEEF00000000`.
  - Request held stable until `addr_ok`, `stall_mem` high throughout.
- `ld` at `0x2000`, `addr_ok & data_ok` in the same cycle 1, `dresp_data=0x0123456789ABCDEF`:
  - `out_valid` at cycle 2 with `memr_data=0x0123456789ABCDEF`.
- `sh` at `0x3001`:
  - No request.
  - `out_valid` next cycle with `is_except=1`, `except_name=E_ST_MISALIGN`.
- `ld` at `0x4000`, `flush` pulsed in WAIT, `data_ok` 2 cycles later:
  - No `out_valid` for the load.
  - Next `in_valid` accepted the cycle after `data_ok`.
- `reset` asserted during REQ:
  - Next cycle `dreq_valid=0`, `stall_mem=0`, `out_valid=0`.

Source files
------------

// File: rtl/memory.sv
// ---------------------------------------------------------------------------
// memory_pkg / memory
//
// Memory-access pipeline stage sitting between execute and writeback.
// One executed instruction is accepted at a time. Loads and stores issue at
// most one data-bus transaction; everything else (and anything already
// carrying an exception or misaligned) passes straight through with a
// one-cycle latency. The raw 64-bit load word is handed to writeback, which
// does byte extraction and sign extension.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   dataE/in_valid  executed instruction from execute and its valid
//   stall_mem       stage busy; upstream holds dataE / in_valid
//   flush           kill the instruction currently held here
//   dataM/out_valid registered result to writeback (one-cycle pulse)
//   dreq_*          data-bus request (address 8-byte aligned, lane-shifted
//                   store data, byte strobes, log2 size)
//   dresp_*         data-bus response (addr_ok, data_ok, raw read word)
// ---------------------------------------------------------------------------

package memory_pkg;

  typedef enum logic [3:0] {
    E_NONE        = 4'd0,
    E_LD_MISALIGN = 4'd1,
    E_ST_MISALIGN = 4'd2,
    E_ILLEGAL     = 4'd3
  } except_name_t;

  typedef struct packed {
    logic         is_except;
    except_name_t except_name;
    logic         csr_we;
    logic [11:0]  csr_addr;
  } csr_ctl_t;

  typedef struct packed {
    logic       regw_en;
    logic       memr_en;
    logic       memw_en;
    logic       mem_unsigned;
    logic [1:0] msize;
  } ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw;
    logic [4:0]  rd;
    ctl_t        ctl;
  } instr_t;

  typedef struct packed {
    instr_t      instr;
    logic [63:0] aluout;
    logic [63:0] srcb;
    csr_ctl_t    csr_ctl;
  } execute_data_t;

  typedef struct packed {
    instr_t      instr;
    logic [63:0] aluout;
    logic [63:0] memr_data;
    csr_ctl_t    csr_ctl;
  } memory_data_t;

endpackage

module memory
  import memory_pkg::*;
#(
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          in_valid,
  output logic          stall_mem,
  input  logic          flush,
  output memory_data_t  dataM,
  output logic          out_valid,
  output logic          dreq_valid,
  output logic [AW-1:0] dreq_addr,
  output logic [2:0]    dreq_size,
  output logic [7:0]    dreq_strobe,
  output logic [63:0]   dreq_data,
  input  logic          dresp_addr_ok,
  input  logic          dresp_data_ok,
  input  logic [63:0]   dresp_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t        state_q,     state_d;
  logic          killed_q,    killed_d;
  instr_t        lat_instr_q, lat_instr_d;
  logic [63:0]   lat_alu_q,   lat_alu_d;
  csr_ctl_t      lat_csr_q,   lat_csr_d;
  memory_data_t  data_m_q,    data_m_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] addr_q,      addr_d;
  logic [2:0]    size_q,      size_d;
  logic [7:0]    strobe_q,    strobe_d;
  logic [63:0]   wdata_q,     wdata_d;

  // Decode of the incoming instruction, used only on the accept cycle.
  logic          in_is_mem;
  logic          in_is_store;
  logic          in_misaligned;
  logic [1:0]    in_msize;
  logic [2:0]    in_offset;
  logic [2:0]    in_align_mask;
  logic [15:0]   in_size_mask;
  logic [15:0]   in_strobe_wide;
  logic [63:0]   in_wdata;
  logic [AW-1:0] in_addr;

  always_comb begin
    in_msize    = dataE.instr.ctl.msize;
    in_offset   = dataE.aluout[2:0];
    in_is_mem   = dataE.instr.ctl.memr_en | dataE.instr.ctl.memw_en;
    in_is_store = dataE.instr.ctl.memw_en;

    unique case (in_msize)
      2'd0:    in_align_mask = 3'b000;
      2'd1:    in_align_mask = 3'b001;
      2'd2:    in_align_mask = 3'b011;
      default: in_align_mask = 3'b111;
    endcase
    in_misaligned = (in_offset & in_align_mask) != 3'b000;

    // Byte-enable run of 2^msize ones, shifted to the access lane. Widened to
    // 16 bits so the 8-byte case does not overflow before truncation.
    in_size_mask   = (16'd1 << (4'd1 << in_msize)) - 16'd1;
    in_strobe_wide = in_size_mask << in_offset;

    in_wdata = dataE.srcb << {in_offset, 3'b000};
    in_addr  = {dataE.aluout[AW-1:3], 3'b000};
  end

  logic complete;

  always_comb begin
    state_d     = state_q;
    killed_d    = killed_q;
    lat_instr_d = lat_instr_q;
    lat_alu_d   = lat_alu_q;
    lat_csr_d   = lat_csr_q;
    data_m_d    = data_m_q;
    out_valid_d = 1'b0;
    addr_d      = addr_q;
    size_d      = size_q;
    strobe_d    = strobe_q;
    wdata_d     = wdata_q;
    complete    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A flush arriving with the accept targets the older instruction,
        // so the newly accepted one always starts un-killed.
        if (in_valid) begin
          lat_instr_d = dataE.instr;
          lat_alu_d   = dataE.aluout;
          lat_csr_d   = dataE.csr_ctl;
          killed_d    = 1'b0;
          if (in_is_mem && !dataE.csr_ctl.is_except && !in_misaligned) begin
            state_d  = S_REQ;
            addr_d   = in_addr;
            size_d   = {1'b0, in_msize};
            strobe_d = in_is_store ? in_strobe_wide[7:0] : 8'h00;
            wdata_d  = in_is_store ? in_wdata : 64'h0;
          end else begin
            // No bus access: result goes out on the next cycle. A misaligned
            // load simply returns zero and writeback raises its exception.
            data_m_d.instr     = dataE.instr;
            data_m_d.aluout    = dataE.aluout;
            data_m_d.memr_data = 64'h0;
            data_m_d.csr_ctl   = dataE.csr_ctl;
            if (in_is_mem && !dataE.csr_ctl.is_except && in_misaligned && in_is_store) begin
              data_m_d.csr_ctl.is_except   = 1'b1;
              data_m_d.csr_ctl.except_name = E_ST_MISALIGN;
            end
            out_valid_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        // A request cannot be withdrawn once issued, so a flush only marks
        // the instruction and the transaction runs to data_ok.
        if (flush) begin
          killed_d = 1'b1;
        end
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            complete = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (flush) begin
          killed_d = 1'b1;
        end
        if (dresp_data_ok) begin
          complete = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      state_d            = S_IDLE;
      killed_d           = 1'b0;
      data_m_d.instr     = lat_instr_q;
      data_m_d.aluout    = lat_alu_q;
      data_m_d.csr_ctl   = lat_csr_q;
      data_m_d.memr_data = lat_instr_q.ctl.memw_en ? 64'h0 : dresp_data;
      // A flush landing on the completion cycle kills it just like an
      // earlier one recorded in killed_q.
      out_valid_d        = !(killed_q || flush);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      killed_q    <= 1'b0;
      lat_instr_q <= '0;
      lat_alu_q   <= '0;
      lat_csr_q   <= '0;
      data_m_q    <= '0;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      strobe_q    <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      killed_q    <= killed_d;
      lat_instr_q <= lat_instr_d;
      lat_alu_q   <= lat_alu_d;
      lat_csr_q   <= lat_csr_d;
      data_m_q    <= data_m_d;
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      strobe_q    <= strobe_d;
      wdata_q     <= wdata_d;
    end
  end

  // Request fields are frozen at accept time, so they stay stable for the
  // whole REQ phase regardless of what upstream drives meanwhile.
  assign dreq_valid  = (state_q == S_REQ);
  assign dreq_addr   = addr_q;
  assign dreq_size   = size_q;
  assign dreq_strobe = strobe_q;
  assign dreq_data   = wdata_q;
  assign stall_mem   = (state_q != S_IDLE);
  assign dataM       = data_m_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_memory.sv
// ---------------------------------------------------------------------------
// tb_memory
//
// Self-checking bench for the memory stage. Each scenario task drives the
// stage, pushes the writeback result it expects onto a queue, and pops and
// compares it when out_valid rises. Bus-side fields are compared inline.
// ---------------------------------------------------------------------------

module tb_memory;
  import memory_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  logic          in_valid;
  logic          stall_mem;
  logic          flush;
  memory_data_t  dataM;
  logic          out_valid;
  logic          dreq_valid;
  logic [63:0]   dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [63:0]   dreq_data;
  logic          dresp_addr_ok;
  logic          dresp_data_ok;
  logic [63:0]   dresp_data;

  int n_compared   = 0;
  int n_mismatched = 0;
  memory_data_t exp_q[$];

  always #5 clk = ~clk;

  memory #(.AW(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .dataE         (dataE),
    .in_valid      (in_valid),
    .stall_mem     (stall_mem),
    .flush         (flush),
    .dataM         (dataM),
    .out_valid     (out_valid),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic execute_data_t mk(input logic ld, input logic st, input logic [1:0] sz,
                                       input logic [63:0] a, input logic [63:0] b);
    execute_data_t e;
    e = '0;
    e.instr.pc           = {32'h0000_8000, $urandom};
    e.instr.raw          = $urandom;
    e.instr.rd           = 5'($urandom);
    e.instr.ctl.memr_en  = ld;
    e.instr.ctl.memw_en  = st;
    e.instr.ctl.msize    = sz;
    e.instr.ctl.regw_en  = !st;
    e.aluout             = a;
    e.srcb               = b;
    e.csr_ctl.csr_addr   = 12'($urandom);
    return e;
  endfunction

  function automatic memory_data_t exp_of(input execute_data_t e, input logic [63:0] rdata);
    memory_data_t m;
    m.instr     = e.instr;
    m.aluout    = e.aluout;
    m.memr_data = rdata;
    m.csr_ctl   = e.csr_ctl;
    return m;
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; dataE = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    step(); step();
    n_compared++;
    if ({out_valid, dreq_valid, stall_mem, dreq_strobe} !== 11'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ctrl: got ov=%b rv=%b st=%b strb=%h want all 0",
               out_valid, dreq_valid, stall_mem, dreq_strobe);
    end
    n_compared++;
    if (dataM !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_dataM: got %h want 0", dataM);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu();
    execute_data_t e;
    memory_data_t  exp;
    logic          saw_req;
    e = mk(1'b0, 1'b0, 2'd3, 64'h1234, 64'h55);
    exp_q.push_back(exp_of(e, 64'h0));
    dataE = e; in_valid = 1'b1;
    step();
    in_valid = 1'b0; dataE = '0;
    saw_req = dreq_valid;
    n_compared++;
    if (out_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL alu_out_valid: got %b want 1", out_valid);
    end
    exp = exp_q.pop_front();
    n_compared++;
    if (dataM !== exp || dataM.aluout !== 64'h1234) begin
      n_mismatched++;
      $display("[TB] FAIL alu_dataM: got %h want %h", dataM, exp);
    end
    step();
    saw_req = saw_req | dreq_valid;
    n_compared++;
    if (out_valid !== 1'b0 || saw_req !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL alu_pulse: got ov=%b req=%b want 0 0", out_valid, saw_req);
    end
  endtask

  task automatic test_store_delayed();
    execute_data_t e;
    memory_data_t  exp;
    e = mk(1'b0, 1'b1, 2'd2, 64'h1004, 64'hDEAD_BEEF);
    exp_q.push_back(exp_of(e, 64'h0));
    dataE = e; in_valid = 1'b1;
    step();
    in_valid = 1'b0; dataE = mk(1'b1, 1'b0, 2'd0, 64'hFFFF, 64'h1);
    for (int k = 0; k < 4; k++) begin
      n_compared++;
      if ({dreq_valid, stall_mem, dreq_addr, dreq_strobe, dreq_data, dreq_size} !==
          {1'b1, 1'b1, 64'h1000, 8'hF0, 64'hDEADBEEF_00000000, 3'd2}) begin
        n_mismatched++;
        $display("[TB] FAIL sw_req[%0d]: got v=%b st=%b a=%h s=%h d=%h z=%0d want 1 1 1000 f0 deadbeef00000000 2",
                 k, dreq_valid, stall_mem, dreq_addr, dreq_strobe, dreq_data, dreq_size);
      end
      if (k == 3) dresp_addr_ok = 1'b1;
      step();
    end
    dresp_addr_ok = 1'b0;
    n_compared++;
    if (dreq_valid !== 1'b0 || stall_mem !== 1'b1 || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL sw_wait: got v=%b st=%b ov=%b want 0 1 0", dreq_valid, stall_mem, out_valid);
    end
    dresp_data_ok = 1'b1; dresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    dresp_data_ok = 1'b0;
    n_compared++;
    if (out_valid !== 1'b1 || stall_mem !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL sw_done: got ov=%b st=%b want 1 0", out_valid, stall_mem);
    end
    exp = exp_q.pop_front();
    n_compared++;
    if (dataM !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL sw_dataM: got %h want %h", dataM, exp);
    end
    dataE = '0;
    step();
  endtask

  task automatic test_load_fast();
    execute_data_t e;
    memory_data_t  exp;
    e = mk(1'b1, 1'b0, 2'd3, 64'h2000, 64'h0);
    exp_q.push_back(exp_of(e, 64'h0123_4567_89AB_CDEF));
    dataE = e; in_valid = 1'b1;
    step();
    in_valid = 1'b0; dataE = '0;
    n_compared++;
    if ({dreq_valid, dreq_addr, dreq_strobe, dreq_size} !== {1'b1, 64'h2000, 8'h00, 3'd3}) begin
      n_mismatched++;
      $display("[TB] FAIL ld_req: got v=%b a=%h s=%h z=%0d want 1 2000 00 3",
               dreq_valid, dreq_addr, dreq_strobe, dreq_size);
    end
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h0123_4567_89AB_CDEF;
    step();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    n_compared++;
    if (out_valid !== 1'b1 || stall_mem !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ld_fast_valid: got ov=%b st=%b want 1 0", out_valid, stall_mem);
    end
    exp = exp_q.pop_front();
    n_compared++;
    if (dataM !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL ld_fast_dataM: got %h want %h", dataM, exp);
    end
    step();
  endtask

  task automatic test_no_bus();
    execute_data_t e;
    memory_data_t  exp;
    memory_data_t  m;
    // Misaligned halfword store: exception, no request.
    e = mk(1'b0, 1'b1, 2'd1, 64'h3001, 64'h1122);
    m = exp_of(e, 64'h0);
    m.csr_ctl.is_except   = 1'b1;
    m.csr_ctl.except_name = E_ST_MISALIGN;
    exp_q.push_back(m);
    dataE = e; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_compared++;
    if (dreq_valid !== 1'b0 || out_valid !== 1'b1 || stall_mem !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL sh_mis_ctrl: got v=%b ov=%b st=%b want 0 1 0", dreq_valid, out_valid, stall_mem);
    end
    exp = exp_q.pop_front();
    n_compared++;
    if (dataM !== exp || dataM.csr_ctl.except_name !== E_ST_MISALIGN) begin
      n_mismatched++;
      $display("[TB] FAIL sh_mis_dataM: got %h want %h", dataM, exp);
    end
    // Misaligned doubleword load: zero data, no exception here.
    e = mk(1'b1, 1'b0, 2'd3, 64'h5004, 64'h0);
    exp_q.push_back(exp_of(e, 64'h0));
    dataE = e; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    exp = exp_q.pop_front();
    n_compared++;
    if (dreq_valid !== 1'b0 || out_valid !== 1'b1 || dataM !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL ld_mis: got v=%b ov=%b d=%h want 0 1 %h", dreq_valid, out_valid, dataM, exp);
    end
    // Aligned load already carrying an exception: no bus access.
    e = mk(1'b1, 1'b0, 2'd2, 64'h6000, 64'h0);
    e.csr_ctl.is_except   = 1'b1;
    e.csr_ctl.except_name = E_ILLEGAL;
    exp_q.push_back(exp_of(e, 64'h0));
    dataE = e; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    exp = exp_q.pop_front();
    n_compared++;
    if (dreq_valid !== 1'b0 || out_valid !== 1'b1 || dataM !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL exc_pass: got v=%b ov=%b d=%h want 0 1 %h", dreq_valid, out_valid, dataM, exp);
    end
    // Stray data_ok while idle must do nothing.
    dataE = '0;
    dresp_data_ok = 1'b1; dresp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    step();
    dresp_data_ok = 1'b0;
    n_compared++;
    if (out_valid !== 1'b0 || stall_mem !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_data_ok: got ov=%b st=%b want 0 0", out_valid, stall_mem);
    end
  endtask

  task automatic test_flush_wait();
    execute_data_t e;
    memory_data_t  exp;
    logic          seen;
    seen = 1'b0;
    e = mk(1'b1, 1'b0, 2'd3, 64'h4000, 64'h0);
    dataE = e; in_valid = 1'b1;
    step();
    in_valid = 1'b0; dataE = '0;
    seen = seen | out_valid;
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    seen = seen | out_valid;
    flush = 1'b1;
    step();
    flush = 1'b0;
    seen = seen | out_valid;
    n_compared++;
    if (stall_mem !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL flush_stall: got %b want 1", stall_mem);
    end
    step();
    seen = seen | out_valid;
    dresp_data_ok = 1'b1; dresp_data = 64'h7777_6666_5555_4444;
    step();
    dresp_data_ok = 1'b0;
    seen = seen | out_valid;
    n_compared++;
    if (seen !== 1'b0 || stall_mem !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL flush_killed: got ov_seen=%b st=%b want 0 0", seen, stall_mem);
    end
    e = mk(1'b0, 1'b0, 2'd0, 64'h9999, 64'h0);
    exp_q.push_back(exp_of(e, 64'h0));
    dataE = e; in_valid = 1'b1;
    step();
    in_valid = 1'b0; dataE = '0;
    exp = exp_q.pop_front();
    n_compared++;
    if (out_valid !== 1'b1 || dataM !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL flush_next: got ov=%b d=%h want 1 %h", out_valid, dataM, exp);
    end
  endtask

  task automatic test_reset_req();
    dataE = mk(1'b0, 1'b1, 2'd3, 64'h6008, 64'h1234_5678);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; dataE = '0;
    n_compared++;
    if (dreq_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL rst_req_pre: got %b want 1", dreq_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_compared++;
    if ({dreq_valid, stall_mem, out_valid, dreq_strobe} !== 11'h0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_req_post: got v=%b st=%b ov=%b s=%h want 0 0 0 00",
               dreq_valid, stall_mem, out_valid, dreq_strobe);
    end
    step();
  endtask

  task automatic test_back_to_back();
    execute_data_t e;
    memory_data_t  exp;
    for (int i = 0; i < 4; i++) begin
      e = mk(1'b0, 1'b0, 2'd0, 64'h100 * i + 64'h7, 64'h0);
      exp_q.push_back(exp_of(e, 64'h0));
      dataE = e; in_valid = 1'b1;
      step();
      exp = exp_q.pop_front();
      n_compared++;
      if (out_valid !== 1'b1 || dataM !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL b2b[%0d]: got ov=%b d=%h want 1 %h", i, out_valid, dataM, exp);
      end
    end
    in_valid = 1'b0; dataE = '0;
    step();
    n_compared++;
    if (out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_end: got %b want 0", out_valid);
    end
  endtask

  task automatic test_random_mem();
    execute_data_t e;
    memory_data_t  exp;
    logic [1:0]    sz;
    logic [2:0]    off;
    logic          st;
    int            ad, dd;
    logic [63:0]   a, b, rdata, exp_data, exp_addr;
    logic [7:0]    exp_strb;
    for (int n = 0; n < 16; n++) begin
      sz    = 2'($urandom_range(0, 3));
      off   = 3'($urandom_range(0, 7));
      off   = off & ~(3'((1 << sz) - 1));
      st    = 1'($urandom);
      ad    = $urandom_range(0, 3);
      dd    = $urandom_range(0, 2);
      a     = {$urandom, $urandom};
      a     = {a[63:3], off};
      b     = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      exp_addr = {a[63:3], 3'b000};
      exp_strb = 8'h00;
      exp_data = 64'h0;
      for (int by = 0; by < 8; by++) begin
        if (st && by >= off && by < off + (1 << sz)) exp_strb[by] = 1'b1;
        if (by >= off) exp_data[8*by +: 8] = b[8*(by - off) +: 8];
      end
      e = mk(!st, st, sz, a, b);
      exp_q.push_back(exp_of(e, st ? 64'h0 : rdata));
      dataE = e; in_valid = 1'b1;
      step();
      in_valid = 1'b0; dataE = '0;
      dresp_data = rdata;
      for (int k = 0; k <= ad; k++) begin
        n_compared++;
        if ({dreq_valid, dreq_addr, dreq_strobe, dreq_size} !== {1'b1, exp_addr, exp_strb, {1'b0, sz}} ||
            (st && dreq_data !== exp_data)) begin
          n_mismatched++;
          $display("[TB] FAIL rand_req[%0d]: got v=%b a=%h s=%h z=%0d d=%h want 1 %h %h %0d %h",
                   n, dreq_valid, dreq_addr, dreq_strobe, dreq_size, dreq_data,
                   exp_addr, exp_strb, sz, exp_data);
        end
        if (k == ad) begin
          dresp_addr_ok = 1'b1;
          dresp_data_ok = (dd == 0);
        end
        step();
      end
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      if (dd > 0) begin
        for (int k = 1; k < dd; k++) begin
          n_compared++;
          if (dreq_valid !== 1'b0 || stall_mem !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rand_wait[%0d]: got v=%b st=%b want 0 1", n, dreq_valid, stall_mem);
          end
          step();
        end
        dresp_data_ok = 1'b1;
        step();
        dresp_data_ok = 1'b0;
      end
      exp = exp_q.pop_front();
      n_compared++;
      if (out_valid !== 1'b1 || dataM !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL rand_resp[%0d]: got ov=%b d=%h want 1 %h", n, out_valid, dataM, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_delayed();
    test_load_fast();
    test_no_bus();
    test_flush_wait();
    test_reset_req();
    test_back_to_back();
    test_random_mem();
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_empty: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
